// File: rtl/vector_strip_counter_if.sv
// Interface between the vector control unit / execute stage and the strip-mining counter.
// master drives load/len/en/abort; slave is the counter that presents chunks.
interface vector_strip_counter_if #(
  parameter int N     = 32,
  parameter int LANES = 4
);
  logic             load;
  logic [N-1:0]     len;
  logic             en;
  logic             abort;
  logic             busy;
  logic             chunk_valid;
  logic [N-1:0]     base_idx;
  logic [LANES-1:0] lane_mask;
  logic             last;
  logic [N-1:0]     remaining;
  logic             done;

  modport master (
    output load, len, en, abort,
    input  busy, chunk_valid, base_idx, lane_mask, last, remaining, done
  );

  modport slave (
    input  load, len, en, abort,
    output busy, chunk_valid, base_idx, lane_mask, last, remaining, done
  );
endinterface

// File: rtl/vector_strip_counter.sv
// Loadable down-counter that strip-mines a len-element vector into LANES-wide chunks.
//   state | meaning
//   IDLE  | no vector in flight, outputs quiet
//   RUN   | presenting a chunk, advances on en, abort returns to IDLE
//   DONE  | one-cycle done pulse, can accept the next load
module vector_strip_counter #(
  parameter int N     = 32,
  parameter int LANES = 4
) (
  input logic                   clk,
  input logic                   rst,
  vector_strip_counter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] LANES_N = N'(LANES);

  state_t       state_q, state_d;
  logic [N-1:0] remaining_q, remaining_d;
  logic [N-1:0] base_q, base_d;
  logic         last_w;

  assign last_w = (remaining_q <= LANES_N);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      base_q      <= base_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    base_d      = base_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.load) begin
          base_d = '0;
          if (bus.len != '0) begin
            state_d     = ST_RUN;
            remaining_d = bus.len;
          end else begin
            state_d     = ST_DONE;
            remaining_d = '0;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
          base_d      = '0;
        end else if (bus.en) begin
          // the last check guarantees remaining - LANES never underflows
          if (last_w) begin
            state_d     = ST_DONE;
            remaining_d = '0;
          end else begin
            remaining_d = remaining_q - LANES_N;
            base_d      = base_q + LANES_N;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = '0;
        base_d      = '0;
      end
    endcase
  end

  always_comb begin
    bus.busy        = (state_q == ST_RUN);
    bus.chunk_valid = (state_q == ST_RUN);
    bus.base_idx    = (state_q == ST_RUN) ? base_q : '0;
    bus.last        = (state_q == ST_RUN) && last_w;
    bus.remaining   = remaining_q;
    bus.done        = (state_q == ST_DONE);
    for (int i = 0; i < LANES; i++) begin
      bus.lane_mask[i] = (state_q == ST_RUN) && (remaining_q > N'(i));
    end
  end
endmodule
